convolution_v3: RTL and testbench

- Streaming 2-D K×K binomial (Gaussian-approximation) filter over a raster-order image of WIDTH×HEIGHT fixed-point pixels.
- Input pixels arrive on one `dstream` valid/ready channel. Filtered pixels leave on a second `dstream` channel.
- Only windows that lie fully inside the image produce an output ("valid" convolution, no padding).
- Sits in the image-processing pipeline between the pixel source and downstream feature stages.

---
 rtl/convolution_v3.sv | 124 ++++++++++++
 tb/tb_convolution_v3.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/convolution_v3.sv
`default_nettype none
// ------------------------------------------------------------------------
// convolution_v3 : streaming KxK binomial filter over a raster image,
// emitting only windows that lie fully inside the frame.      Rev 1.0
// ------------------------------------------------------------------------
module convolution_v3 #(
  parameter int W      = 32,
  parameter int W_FRAC = 16,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int K      = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int SH = 2 * (K - 1);
  localparam int AW = W + SH + 1;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  if (K < 3 || (K % 2) == 0 || W_FRAC > W) begin : g_param_check
    $error("convolution_v3: K must be odd and >= 3, W_FRAC <= W");
  end

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int t = 0; t < k; t++) r = (r * (n - t)) / (t + 1);
    return r;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          y_valid_q, y_valid_d;
  logic [W-1:0]  y_data_q, y_data_d;

  logic [W-1:0]  lb_q  [K-1][WIDTH];
  logic [W-1:0]  win_q [K][K];
  logic [W-1:0]  col_in [K];

  logic                 en;
  logic                 accept;
  logic signed [AW-1:0] acc;

  assign en      = !y_valid_q || y_ready;
  assign accept  = x_valid && en;
  assign x_ready = en;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;

  // Column entering the window: oldest line at index 0, live pixel at K-1.
  always_comb begin
    for (int i = 0; i < K - 1; i++) col_in[i] = lb_q[K-2-i][col_q];
    col_in[K-1] = x_data;
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        acc = acc + AW'(binom(K - 1, i) * binom(K - 1, j)) * AW'($signed(win_q[i][j]));
      end
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    y_valid_d   = y_valid_q;
    y_data_d    = y_data_q;
    if (en) begin
      win_valid_d = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
      y_valid_d   = win_valid_q;
      y_data_d    = W'(acc >>> SH);
    end
    if (accept) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      y_valid_q   <= 1'b0;
      y_data_q    <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      y_valid_q   <= y_valid_d;
      y_data_q    <= y_data_d;
    end
  end

  // Line buffers and window are pure storage; their contents are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= x_data;
      for (int i = 1; i < K - 1; i++) lb_q[i][col_q] <= lb_q[i-1][col_q];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][K-1] <= col_in[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_convolution_v3.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_convolution_v3 : directed bench with a 2-D reference model. Rev 1.0
// ------------------------------------------------------------------------
module tb_convolution_v3;

  localparam int W      = 32;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 12;
  localparam int K      = 5;
  localparam int HALF   = (K - 1) / 2;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int NOUT   = (WIDTH - K + 1) * (HEIGHT - K + 1);
  localparam int IR     = 6;
  localparam int IC     = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] x_data = '0;
  logic         x_valid = 1'b0;
  logic         x_ready;
  logic [W-1:0] y_data;
  logic         y_valid;
  logic         y_ready = 1'b1;

  convolution_v3 #(.W(W), .W_FRAC(16), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .K(K)) dut (
    .clk(clk), .rst(rst),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int          tap [K] = '{1, 4, 6, 4, 1};
  int          img [HEIGHT][WIDTH];
  logic [31:0] dut_out [HEIGHT][WIDTH];
  logic [31:0] q_exp [$];
  int          q_pos [$];
  int          mr = 0, mc = 0, cyc = 0, n_out = 0;
  int          first_win_cyc = -1, first_out_cyc = -1, first_win_idx = -1;
  int          n_chk = 0, n_err = 0;
  bit          stall_prev = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window addressed by its bottom-right pixel (r,c); floor division by 256.
  function automatic logic [31:0] model_out(input int r, input int c);
    longint s;
    s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(tap[i] * tap[j]) * longint'(img[r-K+1+i][c-K+1+j]);
    return 32'(s >>> (2 * (K - 1)));
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_exp.delete();
      q_pos.delete();
      mr = 0;
      mc = 0;
      stall_prev = 1'b0;
      chk("reset_y_valid", 32'(y_valid), 32'd0);
    end else begin
      if (stall_prev) begin
        chk("stall_y_data", y_data, prev_data);
        chk("stall_y_valid", 32'(y_valid), 32'd1);
      end
      chk("x_ready_rule", 32'(x_ready), 32'(!y_valid || y_ready));
      if (y_valid && y_ready) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_output", y_data, 32'hxxxxxxxx);
        end else begin
          logic [31:0] e;
          int p;
          e = q_exp.pop_front();
          p = q_pos.pop_front();
          chk("y_data", y_data, e);
          dut_out[p / WIDTH][p % WIDTH] = y_data;
          n_out++;
          if (first_out_cyc < 0) first_out_cyc = cyc;
        end
      end
      if (x_valid && x_ready) begin
        img[mr][mc] = int'(x_data);
        if (mr >= K - 1 && mc >= K - 1) begin
          q_exp.push_back(model_out(mr, mc));
          q_pos.push_back((mr - HALF) * WIDTH + (mc - HALF));
          if (first_win_cyc < 0) begin
            first_win_cyc = cyc;
            first_win_idx = mr * WIDTH + mc;
          end
        end
        if (mc == WIDTH - 1) begin
          mc = 0;
          mr = (mr == HEIGHT - 1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
      stall_prev = y_valid && !y_ready;
      prev_data  = y_data;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      x_valid = 1'b0;
      x_data  = 'x;
      y_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input int yr_pct, input int gap_pct);
    int tries;
    bit took;
    for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
      x_valid = 1'b0;
      x_data  = 'x;
      y_ready = (int'($urandom_range(99)) < yr_pct);
      @(posedge clk);
      #1;
    end
    x_valid = 1'b1;
    x_data  = d;
    tries   = 0;
    took    = 1'b0;
    do begin
      y_ready = (int'($urandom_range(99)) < yr_pct);
      @(negedge clk);
      took = x_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!took && tries < 200);
    x_valid = 1'b0;
    x_data  = 'x;
    if (!took) chk("send_timeout", 32'(tries), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_y_valid", 32'(y_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mode 0: constant, 1: impulse at (IR,IC), 2: random
  task automatic frame(input int mode, input logic [31:0] val, input int npix,
                       input int yr_pct, input int gap_pct, input int rst_at);
    for (int p = 0; p < npix; p++) begin
      int r, c;
      logic [31:0] d;
      r = (p / WIDTH) % HEIGHT;
      c = p % WIDTH;
      case (mode)
        0:       d = val;
        1:       d = (r == IR && c == IC) ? val : 32'd0;
        default: d = $urandom();
      endcase
      send(d, yr_pct, gap_pct);
      if (p + 1 == rst_at) begin
        do_reset();
        return;
      end
    end
  endtask

  task automatic begin_test();
    n_out = 0;
    first_win_cyc = -1;
    first_out_cyc = -1;
    first_win_idx = -1;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++) dut_out[r][c] = 32'hDEADBEEF;
  endtask

  task automatic finish_test(input string name, input int exp_n);
    idle(8);
    chk({name, "_queue_empty"}, 32'(q_exp.size()), 32'd0);
    chk({name, "_count"}, 32'(n_out), 32'(exp_n));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_y_data", y_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_x_ready", 32'(x_ready), 32'd1);
    idle(2);

    // Constant +1.0 full frame, latency and first-window position
    begin_test();
    frame(0, 32'h00010000, NPIX, 100, 0, -1);
    finish_test("const_pos", NOUT);
    chk("const_pos_first", dut_out[2][2], 32'h00010000);
    chk("const_pos_last", dut_out[HEIGHT-3][WIDTH-3], 32'h00010000);
    chk("latency", 32'(first_out_cyc - first_win_cyc), 32'd2);
    chk("first_win_index", 32'(first_win_idx), 32'd68);

    // Partial frame short of the first complete window
    begin_test();
    frame(0, 32'h00010000, 4 * WIDTH + 3, 100, 0, -1);
    finish_test("partial", 0);
    do_reset();
    idle(2);

    // Positive impulse
    begin_test();
    frame(1, 32'h00010000, NPIX, 100, 0, -1);
    finish_test("impulse", NOUT);
    chk("impulse_centre", dut_out[6][6], 32'h00002400);
    chk("impulse_corner", dut_out[4][4], 32'h00000100);
    chk("impulse_edge",   dut_out[5][6], 32'h00001800);
    chk("impulse_far_c",  dut_out[6][9], 32'h00000000);
    chk("impulse_far_r",  dut_out[9][6], 32'h00000000);

    // Constant -1.0 (follows a full frame, so counters have wrapped)
    begin_test();
    frame(0, 32'hFFFF0000, NPIX, 100, 0, -1);
    finish_test("const_neg", NOUT);
    chk("const_neg_mid", dut_out[5][5], 32'hFFFF0000);
    chk("const_neg_last", dut_out[HEIGHT-3][WIDTH-3], 32'hFFFF0000);

    // -1 LSB impulse: floor shift must give -1, not 0
    begin_test();
    frame(1, 32'hFFFFFFFF, NPIX, 100, 0, -1);
    finish_test("neg_lsb", NOUT);
    chk("neg_lsb_centre", dut_out[6][6], 32'hFFFFFFFF);
    chk("neg_lsb_corner", dut_out[4][4], 32'hFFFFFFFF);
    chk("neg_lsb_side",   dut_out[6][8], 32'hFFFFFFFF);
    chk("neg_lsb_far",    dut_out[6][9], 32'h00000000);

    // Random data with backpressure, reset mid-frame, then a clean frame
    begin_test();
    frame(2, 32'd0, NPIX, 60, 20, 5 * WIDTH + 3);
    idle(2);
    begin_test();
    frame(2, 32'd0, NPIX, 60, 20, -1);
    finish_test("random", NOUT);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
